// File: rtl/wb_port_arbiter_pkg.sv
// Shared core constants for the writeback path.
//   XLEN       - architectural data width
//   REG_AW     - register address width
//   NUM_REGS   - number of architectural registers
//   WB_*       - writeback requester indices on the shared write port
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  localparam int unsigned WB_ALU    = 0;
  localparam int unsigned WB_LOAD   = 1;
  localparam int unsigned WB_MULDIV = 2;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : request vector
//   grant_o    : one-hot grant (combinational from valid_i and pointer),
//                held at zero while reset is asserted
// The search starts at the pointer; after a grant to g the pointer moves
// to g+1 (mod N). The pointer holds when nothing is granted.
module rr_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant;
  logic [PW-1:0] gidx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p,
                                             input int unsigned k);
    int unsigned s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == '0 && valid_i[wrap_add(ptr_q, k)]) begin
        grant[wrap_add(ptr_q, k)] = 1'b1;
        gidx                      = wrap_add(ptr_q, k);
      end
    end
    ptr_d = (grant != '0) ? wrap_add(gidx, 1) : ptr_q;
  end

  assign grant_o = grant & {N{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
//   req_valid/req_ready/req_rd/req_data : writeback requesters (packed per index)
//   issue_valid/issue_rd                : issue-stage destination reservation
//   flush                               : clears the scoreboard
//   rf_we/rf_waddr/rf_wdata             : registered register-file write port
//   busy                                : per-register pending-write bits (bit 0 = 0)
//   err_waw                             : sticky issue-to-busy-register error
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = wb_port_arbiter_pkg::XLEN,
  parameter int unsigned REG_AW  = wb_port_arbiter_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [2**REG_AW-1:0]      busy,
  output logic                      err_waw
);

  logic [NUM_REQ-1:0]   grant;
  logic                 xfer;
  logic [REG_AW-1:0]    sel_rd;
  logic [XLEN-1:0]      sel_data;
  logic                 issue_set;

  logic                 rf_we_q, rf_we_d;
  logic [REG_AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic [2**REG_AW-1:0] busy_q, busy_d;
  logic                 err_q, err_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign issue_set = issue_valid && (issue_rd != '0);

  // Grant is one-hot, so OR-reduction acts as the select mux.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd[i*REG_AW +: REG_AW];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rf_we_d    = xfer && (sel_rd != '0);
    rf_waddr_d = xfer ? sel_rd   : rf_waddr_q;
    rf_wdata_d = xfer ? sel_data : rf_wdata_q;

    // Clear first, then set, so a same-cycle reissue keeps the bit; flush overrides both.
    busy_d = busy_q;
    if (xfer)      busy_d[sel_rd]   = 1'b0;
    if (issue_set) busy_d[issue_rd] = 1'b1;
    if (flush)     busy_d           = '0;
    busy_d[0] = 1'b0;

    err_d = err_q;
    if (issue_set && busy_q[issue_rd] && !(xfer && sel_rd == issue_rd))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign err_waw  = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (3 requesters, 64-bit data).
module tb_wb_port_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned XL = 64;
  localparam int unsigned AW = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*AW-1:0]   req_rd;
  logic [NR*XL-1:0]   req_data;
  logic               issue_valid;
  logic [AW-1:0]      issue_rd;
  logic               flush;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [XL-1:0]      rf_wdata;
  logic [2**AW-1:0]   busy;
  logic               err_waw;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  wb_port_arbiter #(.NUM_REQ(NR), .XLEN(XL), .REG_AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err_waw     (err_waw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs are then driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] rd, input logic [XL-1:0] d);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*XL +: XL] = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 3'b111;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
    set_req(0, 5'd5, 64'h1111);
    set_req(1, 5'd6, 64'h2222);
    set_req(2, 5'd7, 64'h3333);

    // Reset with all requesters valid
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_we",    64'(rf_we),     64'h0);
    chk("rst_busy",  64'(busy),      64'h0);
    chk("rst_err",   64'(err_waw),   64'h0);
    chk("rst_waddr", 64'(rf_waddr),  64'h0);

    // Release: first grant to index 0, then round-robin 1, 2
    rst_n = 1'b1;
    #1;
    chk("rr_g0", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b110; #1;
    chk("rr_g1",  64'(req_ready), 64'b010);
    chk("rr_we0", 64'(rf_we),     64'h1);
    chk("rr_a0",  64'(rf_waddr),  64'd5);
    chk("rr_d0",  rf_wdata,       64'h1111);
    tick();
    req_valid = 3'b100; #1;
    chk("rr_g2",  64'(req_ready), 64'b100);
    chk("rr_we1", 64'(rf_we),     64'h1);
    chk("rr_a1",  64'(rf_waddr),  64'd6);
    chk("rr_d1",  rf_wdata,       64'h2222);
    tick();
    req_valid = 3'b000; #1;
    chk("rr_none", 64'(req_ready), 64'b000);
    chk("rr_we2",  64'(rf_we),     64'h1);
    chk("rr_a2",   64'(rf_waddr),  64'd7);
    chk("rr_d2",   rf_wdata,       64'h3333);
    tick();
    chk("idle_we",   64'(rf_we),    64'h0);
    chk("idle_hold", 64'(rf_waddr), 64'd7);
    chk("idle_dhold", rf_wdata,     64'h3333);

    // Scoreboard set at issue, cleared at grant (ptr now 0)
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("sb_set9", 64'(busy), 64'h200);
    set_req(0, 5'd9, 64'hDEAD_BEEF);
    req_valid = 3'b001; #1;
    chk("sb_gnt", 64'(req_ready), 64'b001);
    chk("sb_pre", 64'(busy),      64'h200);
    tick();
    req_valid = 3'b000;
    chk("sb_clr9", 64'(busy),     64'h0);
    chk("sb_we",   64'(rf_we),    64'h1);
    chk("sb_a",    64'(rf_waddr), 64'd9);
    chk("sb_d",    rf_wdata,      64'hDEAD_BEEF);

    // Same-cycle reissue and retire of rd 9 (ptr now 1 -> load granted)
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    set_req(1, 5'd9, 64'hABC);
    req_valid = 3'b010; #1;
    chk("same_gnt", 64'(req_ready), 64'b010);
    tick();
    issue_valid = 1'b0; req_valid = 3'b000;
    chk("same_busy", 64'(busy),    64'h200);
    chk("same_err",  64'(err_waw), 64'h0);
    chk("same_we",   64'(rf_we),   64'h1);

    // x0: load request rd 0 still granted, no write; issue rd 0 ignored (ptr now 2)
    set_req(1, 5'd0, 64'h55);
    req_valid = 3'b010; issue_valid = 1'b1; issue_rd = 5'd0; #1;
    chk("x0_gnt", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000; issue_valid = 1'b0;
    chk("x0_we",   64'(rf_we),   64'h0);
    chk("x0_busy", 64'(busy),    64'h200);
    chk("x0_err",  64'(err_waw), 64'h0);

    // Retire rd 9 via mul/div (ptr now 2)
    set_req(2, 5'd9, 64'h99);
    req_valid = 3'b100; #1;
    chk("md_gnt", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b000;
    chk("md_busy", 64'(busy), 64'h0);

    // Flush with same-cycle issue 12 and grant rd 3 (ptr now 0)
    issue_valid = 1'b1; issue_rd = 5'd3;  tick();
    issue_rd = 5'd4;  tick();
    issue_rd = 5'd10; tick();
    chk("fl_pre", 64'(busy), 64'h418);
    issue_rd = 5'd12; flush = 1'b1;
    set_req(0, 5'd3, 64'h3333_0000);
    req_valid = 3'b001; #1;
    chk("fl_gnt", 64'(req_ready), 64'b001);
    tick();
    issue_valid = 1'b0; flush = 1'b0; req_valid = 3'b000;
    chk("fl_busy", 64'(busy),     64'h0);
    chk("fl_we",   64'(rf_we),    64'h1);
    chk("fl_a",    64'(rf_waddr), 64'd3);
    chk("fl_d",    rf_wdata,      64'h3333_0000);

    // Pointer wrap (ptr now 1): valid 101 -> grant 2, then grant 0
    set_req(0, 5'd20, 64'h20);
    set_req(2, 5'd21, 64'h21);
    req_valid = 3'b101; #1;
    chk("wr_g2", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b001; #1;
    chk("wr_g0", 64'(req_ready), 64'b001);
    chk("wr_a2", 64'(rf_waddr),  64'd21);
    tick();
    req_valid = 3'b000;
    chk("wr_a0", 64'(rf_waddr), 64'd20);
    chk("wr_d0", rf_wdata,      64'h20);

    // WAW: issue rd 7 twice, flag sticks
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    chk("waw_no", 64'(err_waw), 64'h0);
    tick();
    issue_valid = 1'b0;
    chk("waw_set",  64'(err_waw), 64'h1);
    chk("waw_busy", 64'(busy),    64'h80);
    tick(); tick();
    chk("waw_stick", 64'(err_waw), 64'h1);

    // Reset mid-operation clears everything
    rst_n = 1'b0; req_valid = 3'b111; #1;
    chk("rst2_err",   64'(err_waw),   64'h0);
    chk("rst2_busy",  64'(busy),      64'h0);
    chk("rst2_ready", 64'(req_ready), 64'h0);
    tick();
    rst_n = 1'b1; #1;
    chk("rst2_g0", 64'(req_ready), 64'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
